// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//
// Word-level controller wrapped around a serial Moore pattern matcher.
// A parallel word is taken over a valid/ready handshake, shifted MSB-first
// into the matcher one bit per clock, and the number of overlapping pattern
// hits in that word is returned over a second valid/ready handshake.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     producer has a word
//   in_ready     controller can accept a word (IDLE and not in reset)
//   in_data      word to scan, MSB is shifted first
//   det_y        registered Moore detector output, one cycle high per hit
//   busy         controller is not IDLE
//   out_valid    result available (REPORT state)
//   out_ready    consumer takes the result
//   match_count  hits found in the current word, saturating
//   match_flag   match_count != 0
//
// Parameters
//   WORD_W     bits per input word (>= PAT_W)
//   PAT_W      pattern length in bits (>= 1)
//   PATTERN    pattern to detect, oldest bit in the MSB
//   CNT_W      width of the per-word match counter
//   KEEP_HIST  1: matcher history runs on across words as one stream
//              0: matcher history is cleared whenever a word is accepted
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
    parameter int               WORD_W    = 8,
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PATTERN   = 4'b1010,
    parameter int               CNT_W     = 4,
    parameter bit               KEEP_HIST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              det_y,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_count,
    output logic              match_flag
);

    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORD_W-1:0] word;      // word being scanned, captured at accept
    logic [IDX_W-1:0]  bit_idx;   // index of the next bit to shift
    logic [PAT_W-1:0]  hist;      // last PAT_W bits seen, newest in the LSB
    logic [FILL_W-1:0] fill;      // how many valid bits hist holds, caps at PAT_W

    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic              cur_bit;
    logic              hit;
    logic              accept;
    logic              last_bit;

    // -------------------------------------------------------------------------
    // Handshake and status outputs
    // -------------------------------------------------------------------------
    // rst is folded in so the producer never sees ready while the block is
    // being held in reset.
    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign out_valid  = (state == REPORT);
    assign match_flag = (match_count != '0);
    assign last_bit   = (bit_idx == '0);

    // -------------------------------------------------------------------------
    // Matcher next-value logic
    // -------------------------------------------------------------------------
    // The match decision looks at the history *after* this edge's shift, so
    // det_y lines up with the bit that completed the pattern.
    always_comb begin
        cur_bit  = word[bit_idx];
        hist_nxt = (hist << 1) | PAT_W'(cur_bit);
        fill_nxt = (fill == FILL_FULL) ? fill : fill + 1'b1;
        // Without the fill qualifier, a reset-cleared history of zeros would
        // report a false hit for an all-zero pattern before PAT_W bits arrive.
        hit      = (hist_nxt == PATTERN) && (fill_nxt == FILL_FULL);
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = REPORT;
            REPORT:  if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Word capture
    // -------------------------------------------------------------------------
    // NOTE: the word register is pure data, only read in SHIFT after an accept
    // has loaded it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            word <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Matcher state, bit counter, hit counter and registered detector output
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx     <= '0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            det_y       <= 1'b0;
        end else begin
            // det_y is only ever high on the edge right after a shift.
            det_y <= 1'b0;

            if (accept) begin
                bit_idx     <= LAST_IDX;
                match_count <= '0;
                if (!KEEP_HIST) begin
                    hist <= '0;
                    fill <= '0;
                end
            end else if (state == SHIFT) begin
                // Overlapping matches: hist is never cleared on a hit.
                hist    <= hist_nxt;
                fill    <= fill_nxt;
                bit_idx <= bit_idx - 1'b1;
                det_y   <= hit;
                if (hit && (match_count != CNT_MAX)) begin
                    match_count <= match_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
//
// Three instances of seq_det_ctrl run in lockstep on the same stimulus:
//   u_def   default parameters (pattern 1010, history cleared per word)
//   u_keep  KEEP_HIST=1 (history runs on across words)
//   u_sat   PAT_W=2, PATTERN=2'b11, CNT_W=2 (exercises counter saturation)
// Each instance is compared against a bit-stream model: the serial bits are
// appended to a queue and a hit is declared whenever the newest PAT_W bits
// of the queue spell the pattern.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready_d, det_y_d, busy_d, out_valid_d, match_flag_d;
    logic [3:0] match_count_d;
    logic       in_ready_k, det_y_k, busy_k, out_valid_k, match_flag_k;
    logic [3:0] match_count_k;
    logic       in_ready_s, det_y_s, busy_s, out_valid_s, match_flag_s;
    logic [1:0] match_count_s;

    always #5 clk = ~clk;

    seq_det_ctrl u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
        .in_data(in_data), .det_y(det_y_d), .busy(busy_d),
        .out_valid(out_valid_d), .out_ready(out_ready),
        .match_count(match_count_d), .match_flag(match_flag_d)
    );

    seq_det_ctrl #(.KEEP_HIST(1'b1)) u_keep (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_k),
        .in_data(in_data), .det_y(det_y_k), .busy(busy_k),
        .out_valid(out_valid_k), .out_ready(out_ready),
        .match_count(match_count_k), .match_flag(match_flag_k)
    );

    seq_det_ctrl #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .det_y(det_y_s), .busy(busy_s),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .match_count(match_count_s), .match_flag(match_flag_s)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: serial bit streams and raw hit counts.
    bit q_d[$];
    bit q_k[$];
    bit q_s[$];
    int hits_d = 0;
    int hits_k = 0;
    int hits_s = 0;
    logic [7:0] trace_d;
    logic [7:0] trace_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // True when the newest pw bits of the stream equal pat (newest = pat[0]).
    function automatic bit hit_now(input bit q[$], input int pw, input logic [3:0] pat);
        if (q.size() < pw) return 1'b0;
        for (int j = 0; j < pw; j++) begin
            if (q[q.size() - 1 - j] != pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_clear_all();
        q_d.delete();
        q_k.delete();
        q_s.delete();
        hits_d = 0;
        hits_k = 0;
        hits_s = 0;
    endtask

    task automatic check_status(input string tag, input bit b, input bit ov, input bit ir);
        chk({tag, "_busy_def"},  32'(busy_d),      32'(b));
        chk({tag, "_busy_keep"}, 32'(busy_k),      32'(b));
        chk({tag, "_busy_sat"},  32'(busy_s),      32'(b));
        chk({tag, "_ov_def"},    32'(out_valid_d), 32'(ov));
        chk({tag, "_ov_keep"},   32'(out_valid_k), 32'(ov));
        chk({tag, "_ov_sat"},    32'(out_valid_s), 32'(ov));
        chk({tag, "_ir_def"},    32'(in_ready_d),  32'(ir));
        chk({tag, "_ir_keep"},   32'(in_ready_k),  32'(ir));
        chk({tag, "_ir_sat"},    32'(in_ready_s),  32'(ir));
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_cnt_def"},   32'(match_count_d), 32'(sat(hits_d, 15)));
        chk({tag, "_flag_def"},  32'(match_flag_d),  32'(hits_d != 0));
        chk({tag, "_cnt_keep"},  32'(match_count_k), 32'(sat(hits_k, 15)));
        chk({tag, "_flag_keep"}, 32'(match_flag_k),  32'(hits_k != 0));
        chk({tag, "_cnt_sat"},   32'(match_count_s), 32'(sat(hits_s, 3)));
        chk({tag, "_flag_sat"},  32'(match_flag_s),  32'(hits_s != 0));
    endtask

    // One full word transaction: accept, WORD_W shift edges, REPORT held for
    // 'hold' extra cycles of backpressure, then back to IDLE. With keep_valid
    // set, in_valid stays high throughout (it must be ignored outside IDLE).
    task automatic run_word(input logic [7:0] w, input int hold, input bit keep_valid);
        int n;
        bit hd, hk, hs;
        n = 0;
        while (in_ready_d !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(in_ready_d), 32'd1);

        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b0;
        // Stream model at accept: counts restart, history only for non-keep.
        q_d.delete();
        q_s.delete();
        hits_d = 0;
        hits_k = 0;
        hits_s = 0;
        tick();
        in_valid = keep_valid;
        in_data  = 8'($urandom);   // must not disturb the word in flight

        for (int i = 7; i >= 0; i--) begin
            q_d.push_back(w[i]);
            q_k.push_back(w[i]);
            q_s.push_back(w[i]);
            hd = hit_now(q_d, 4, 4'b1010);
            hk = hit_now(q_k, 4, 4'b1010);
            hs = hit_now(q_s, 2, 4'b0011);
            hits_d += int'(hd);
            hits_k += int'(hk);
            hits_s += int'(hs);
            tick();
            trace_d[i] = det_y_d;
            trace_k[i] = det_y_k;
            chk($sformatf("det_def_b%0d", i),  32'(det_y_d), 32'(hd));
            chk($sformatf("det_keep_b%0d", i), 32'(det_y_k), 32'(hk));
            chk($sformatf("det_sat_b%0d", i),  32'(det_y_s), 32'(hs));
            // out_valid must appear exactly after edge E+WORD_W.
            check_status("shift", 1'b1, (i == 0), 1'b0);
        end

        for (int h = 0; h <= hold; h++) begin
            check_status("report", 1'b1, 1'b1, 1'b0);
            check_counts("report");
            if (h > 0) begin
                chk("report_det_def",  32'(det_y_d), 32'd0);
                chk("report_det_keep", 32'(det_y_k), 32'd0);
                chk("report_det_sat",  32'(det_y_s), 32'd0);
            end
            if (h == hold) out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;

        check_status("idle", 1'b0, 1'b0, 1'b1);
        check_counts("idle_hold");
        chk("idle_det_def", 32'(det_y_d), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state --------------------------------------------------
        #1 rst = 1'b1;
        #1;
        check_status("reset", 1'b0, 1'b0, 1'b0);
        check_counts("reset");
        chk("reset_det_def", 32'(det_y_d), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear_all();
        #1;
        check_status("post_reset", 1'b0, 1'b0, 1'b1);

        // ---- 1010_1010: hits after shift edges 4, 6, 8 ---------------------
        run_word(8'b1010_1010, 0, 1'b0);
        chk("aa_trace_def", 32'(trace_d), 32'h15);
        chk("aa_count_def", 32'(match_count_d), 32'd3);
        chk("aa_flag_def",  32'(match_flag_d), 32'd1);

        // ---- all zeros: no hits --------------------------------------------
        run_word(8'h00, 0, 1'b0);
        chk("zero_trace_def", 32'(trace_d), 32'h00);
        chk("zero_count_def", 32'(match_count_d), 32'd0);
        chk("zero_flag_def",  32'(match_flag_d), 32'd0);

        // ---- history across words ------------------------------------------
        run_word(8'b0000_0101, 0, 1'b0);
        chk("kh1_count_keep", 32'(match_count_k), 32'd0);
        run_word(8'b0111_1111, 0, 1'b0);
        chk("kh2_count_keep", 32'(match_count_k), 32'd1);
        chk("kh2_trace_keep", 32'(trace_k), 32'h80);
        chk("kh2_count_def",  32'(match_count_d), 32'd0);

        // ---- backpressure with in_valid held high, then back-to-back -------
        run_word(8'b1010_1010, 5, 1'b1);
        run_word(8'h0F, 0, 1'b0);

        // ---- counter saturation: 7 raw hits of 11 in FF --------------------
        run_word(8'hFF, 0, 1'b0);
        chk("ff_count_sat", 32'(match_count_s), 32'd3);
        chk("ff_flag_sat",  32'(match_flag_s), 32'd1);
        chk("ff_count_def", 32'(match_count_d), 32'd0);

        // ---- asynchronous reset mid-SHIFT ----------------------------------
        in_valid = 1'b1;
        in_data  = 8'b1010_1010;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_det_def_before", 32'(det_y_d), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_status("mid_reset", 1'b0, 1'b0, 1'b0);
        chk("mid_reset_det_def",  32'(det_y_d), 32'd0);
        chk("mid_reset_det_keep", 32'(det_y_k), 32'd0);
        chk("mid_reset_cnt_def",  32'(match_count_d), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear_all();
        tick();
        check_status("after_mid_reset", 1'b0, 1'b0, 1'b1);
        run_word(8'b1010_1010, 0, 1'b0);
        chk("fresh_count_def", 32'(match_count_d), 32'd3);

        // ---- randomized words ----------------------------------------------
        for (int r = 0; r < 20; r++) begin
            run_word(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
